float_to_int_cvt: RTL and testbench

// Parametrised IEEE-754 float to integer converter. Successor to the fixed binary32->int32 converter.
// - Generic exponent, mantissa and integer widths.
// - Per-transaction signed/unsigned mode and 4 rounding modes.
// - Saturation and exception flags.

---
 rtl/fp_cvt_pkg.sv | 34 +++
 rtl/fp_round_inc.sv | 25 ++
 rtl/float_to_int_cvt.sv | 204 ++++++++++++++++++++
 tb/tb_float_to_int_cvt.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt_pkg.sv
// Shared types and constants for the float-to-integer conversion datapath.
// Rounding-mode encoding matches the in_rm port; flag indices address out_flags.
package fp_cvt_pkg;

   typedef enum logic [1:0] {
      RNE = 2'd0,
      RTZ = 2'd1,
      RDN = 2'd2,
      RUP = 2'd3
   } rm_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      UNPACK  = 3'd1,
      SPECIAL = 3'd2,
      ALIGN   = 3'd3,
      ROUND   = 3'd4,
      OUTPUT  = 3'd5
   } state_t;

   localparam int FL_NAN = 2;
   localparam int FL_OVF = 1;
   localparam int FL_INX = 0;

   function automatic logic [2:0] mk_flags(input logic nan, input logic ovf, input logic inx);
      logic [2:0] f;
      f         = 3'b000;
      f[FL_NAN] = nan;
      f[FL_OVF] = ovf;
      f[FL_INX] = inx;
      return f;
   endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Rounding-increment decision from the kept lsb, guard and sticky bits.
// Combinational; reusable by any FP block that truncates a magnitude.
module fp_round_inc
   import fp_cvt_pkg::*;
(
   input  rm_t  rm,
   input  logic sign,
   input  logic lsb,
   input  logic g,
   input  logic st,
   output logic inc
);

   always_comb begin
      inc = 1'b0;
      case (rm)
         RNE:     inc = g & (st | lsb);
         RTZ:     inc = 1'b0;
         RDN:     inc = sign & (g | st);
         RUP:     inc = ~sign & (g | st);
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/float_to_int_cvt.sv
// Parametrised IEEE-754 float to integer converter with strobe/ack handshakes,
// per-operand signed/unsigned mode, four rounding modes and saturation flags.
module float_to_int_cvt
   import fp_cvt_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [1:0]             in_rm,
   input  logic                   in_signed,
   input  logic                   in_stb,
   output logic                   in_ack,
   output logic [INT_W-1:0]       out_z,
   output logic [2:0]             out_flags,
   output logic                   out_stb,
   input  logic                   out_ack
);

   localparam int F_W    = 1 + EXP_W + MAN_W;
   localparam int E_W    = EXP_W + 2;
   // m must hold both the unpacked significand and the largest in-range integer.
   localparam int M_W    = (MAN_W + 1 > INT_W) ? MAN_W + 1 : INT_W;
   localparam int SH_MAX = MAN_W + 2;
   localparam int CNT_W  = $clog2(MAN_W + 3);

   localparam logic signed [E_W-1:0] BIAS     = E_W'((1 << (EXP_W - 1)) - 1);
   localparam logic [INT_W:0]        SMAX_MAG = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [INT_W:0]        SMIN_MAG = {2'b01, {(INT_W-1){1'b0}}};

   state_t                  state;
   logic [F_W-1:0]          a_q;
   rm_t                     rm_q;
   logic                    signed_q;
   logic                    s;
   logic signed [E_W-1:0]   e;
   logic [M_W-1:0]          m;
   logic                    g;
   logic                    st;
   logic [CNT_W-1:0]        sh_cnt;

   logic [EXP_W-1:0]        a_exp;
   logic [MAN_W-1:0]        a_frac;
   logic                    exp_ones;
   logic                    exp_zero;
   logic                    frac_zero;

   logic                    inc;
   logic [INT_W:0]          mag;
   logic                    rnd_ovf;
   logic                    rnd_inx;
   logic [INT_W-1:0]        rnd_z;

   assign a_exp     = a_q[F_W-2:MAN_W];
   assign a_frac    = a_q[MAN_W-1:0];
   assign exp_ones  = &a_exp;
   assign exp_zero  = ~|a_exp;
   assign frac_zero = ~|a_frac;

   // Saturation target; a NaN uses the positive value (neg=0).
   function automatic logic [INT_W-1:0] sat_val(input logic sgn_mode, input logic neg);
      if (sgn_mode)
         return neg ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
      else
         return neg ? {INT_W{1'b0}} : {INT_W{1'b1}};
   endfunction

   fp_round_inc u_round_inc (
      .rm   (rm_q),
      .sign (s),
      .lsb  (m[0]),
      .g    (g),
      .st   (st),
      .inc  (inc)
   );

   // After alignment m holds the truncated integer magnitude, which always fits INT_W bits.
   always_comb begin
      mag     = {1'b0, m[INT_W-1:0]} + {{INT_W{1'b0}}, inc};
      rnd_ovf = 1'b0;
      rnd_z   = '0;
      if (signed_q)
         rnd_ovf = s ? (mag > SMIN_MAG) : (mag > SMAX_MAG);
      else
         rnd_ovf = mag[INT_W] | (s & (mag != '0));
      if (rnd_ovf)
         rnd_z = sat_val(signed_q, s);
      else if (s)
         rnd_z = -mag[INT_W-1:0];
      else
         rnd_z = mag[INT_W-1:0];
      rnd_inx = (g | st) & ~rnd_ovf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ack    <= 1'b0;
         out_stb   <= 1'b0;
         out_z     <= '0;
         out_flags <= '0;
         a_q       <= '0;
         rm_q      <= RNE;
         signed_q  <= 1'b0;
         s         <= 1'b0;
         e         <= '0;
         m         <= '0;
         g         <= 1'b0;
         st        <= 1'b0;
         sh_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_stb && in_ack) begin
                  a_q      <= in_a;
                  rm_q     <= rm_t'(in_rm);
                  signed_q <= in_signed;
                  in_ack   <= 1'b0;
                  state    <= UNPACK;
               end else begin
                  in_ack <= 1'b1;
               end
            end

            UNPACK: begin
               s      <= a_q[F_W-1];
               e      <= $signed({2'b00, a_exp}) - BIAS;
               m      <= M_W'({1'b1, a_frac});
               g      <= 1'b0;
               st     <= 1'b0;
               sh_cnt <= '0;
               state  <= SPECIAL;
            end

            SPECIAL: begin
               if (exp_ones && !frac_zero) begin
                  out_z     <= sat_val(signed_q, 1'b0);
                  out_flags <= mk_flags(1'b1, 1'b0, 1'b0);
                  out_stb   <= 1'b1;
                  state     <= OUTPUT;
               end else if (exp_ones || int'(e) >= INT_W) begin
                  out_z     <= sat_val(signed_q, s);
                  out_flags <= mk_flags(1'b0, 1'b1, 1'b0);
                  out_stb   <= 1'b1;
                  state     <= OUTPUT;
               end else if (exp_zero && frac_zero) begin
                  out_z     <= '0;
                  out_flags <= '0;
                  out_stb   <= 1'b1;
                  state     <= OUTPUT;
               end else if (exp_zero) begin
                  // Any denormal is below 1: only the sticky bit survives.
                  m     <= '0;
                  g     <= 1'b0;
                  st    <= 1'b1;
                  state <= ROUND;
               end else if (int'(e) == MAN_W) begin
                  state <= ROUND;
               end else begin
                  state <= ALIGN;
               end
            end

            ALIGN: begin
               if (int'(e) < MAN_W) begin
                  m      <= m >> 1;
                  g      <= m[0];
                  st     <= st | g;
                  e      <= e + E_W'(1);
                  sh_cnt <= sh_cnt + CNT_W'(1);
                  // Past SH_MAX shifts m is zero and g/st can no longer change.
                  if (int'(e) + 1 == MAN_W || int'(sh_cnt) + 1 == SH_MAX)
                     state <= ROUND;
               end else begin
                  m <= m << 1;
                  e <= e - E_W'(1);
                  if (int'(e) - 1 == MAN_W)
                     state <= ROUND;
               end
            end

            ROUND: begin
               out_z     <= rnd_z;
               out_flags <= mk_flags(1'b0, rnd_ovf, rnd_inx);
               out_stb   <= 1'b1;
               state     <= OUTPUT;
            end

            OUTPUT: begin
               if (out_ack) begin
                  out_stb <= 1'b0;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_int_cvt.sv
// Directed bench for float_to_int_cvt (binary32 -> int32): reference model on
// real operand values, scoreboard of expected results and result latencies.
module tb_float_to_int_cvt;

   logic        clk;
   logic        rst;
   logic [31:0] in_a;
   logic [1:0]  in_rm;
   logic        in_signed;
   logic        in_stb;
   logic        in_ack;
   logic [31:0] out_z;
   logic [2:0]  out_flags;
   logic        out_stb;
   logic        out_ack;

   int          checks;
   int          errors;
   int          cyc;
   logic [34:0] exp_q[$];
   int          lat_q[$];

   float_to_int_cvt dut (
      .clk       (clk),
      .rst       (rst),
      .in_a      (in_a),
      .in_rm     (in_rm),
      .in_signed (in_signed),
      .in_stb    (in_stb),
      .in_ack    (in_ack),
      .out_z     (out_z),
      .out_flags (out_flags),
      .out_stb   (out_stb),
      .out_ack   (out_ack)
   );

   // clock / reset-free cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // directed vectors with hand-computed results
   logic [31:0] dv_a  [16] = '{32'h3FC00000, 32'h3FC00000, 32'hC0200000, 32'hC0200000,
                               32'hC0200000, 32'h4F000000, 32'h4F000000, 32'hCF000000,
                               32'h7FC00000, 32'hFF800000, 32'hBF800000, 32'h00000001,
                               32'h00000001, 32'h80000000, 32'hBECCCCCD, 32'h3F800000};
   logic [1:0]  dv_rm [16] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0,
                               2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
   logic        dv_sg [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] dv_z  [16] = '{32'h00000002, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFD,
                               32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                               32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000001,
                               32'h00000000, 32'h00000000, 32'h00000000, 32'h00000001};
   logic [2:0]  dv_f  [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b000, 3'b000,
                               3'b100, 3'b010, 3'b010, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000};

   // extra operands swept over every mode, checked against the model only
   logic [31:0] sw_a  [14] = '{32'h3F000000, 32'h3F400000, 32'hBF000000, 32'h4B800001,
                               32'hCF000001, 32'h4F800000, 32'h4F7FFFFF, 32'h7F800000,
                               32'h7FFFFFFF, 32'h00400000, 32'hC2F60000, 32'h41C80000,
                               32'h3EFFFFFF, 32'h40490FDB};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] sat32(input logic sg, input logic neg);
      if (sg) return neg ? 32'h80000000 : 32'h7FFFFFFF;
      return neg ? 32'h00000000 : 32'hFFFFFFFF;
   endfunction

   // Value-level model: exact quotient/remainder of the operand, then rounding by remainder vs half.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [1:0] rm, input logic sg);
      logic   s;
      int     ex;
      int     e2;
      int     sh;
      longint mm, q, r, half, mag, val;
      logic   up, ovf, inx;
      logic [31:0] z;
      s  = a[31];
      ex = int'(a[30:23]);
      if (ex == 255 && a[22:0] != 0) return {3'b100, sg ? 32'h7FFFFFFF : 32'hFFFFFFFF};
      if (ex == 255 || ex - 127 >= 32) return {3'b010, sat32(sg, s)};
      if (ex == 0 && a[22:0] == 0) return 35'd0;
      mm   = (ex == 0) ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
      e2   = (ex == 0) ? -149 : ex - 150;
      r    = 0;
      half = 1;
      if (e2 >= 0) begin
         q = mm << e2;
      end else begin
         sh = -e2;
         if (sh >= 40) begin
            q    = 0;
            r    = mm;
            half = longint'(1) << 39;
         end else begin
            q    = mm >> sh;
            r    = mm - (q << sh);
            half = longint'(1) << (sh - 1);
         end
      end
      case (rm)
         2'd0:    up = (r > half) || (r == half && q[0]);
         2'd1:    up = 1'b0;
         2'd2:    up = s && (r != 0);
         default: up = !s && (r != 0);
      endcase
      mag = q + longint'(up);
      val = s ? -mag : mag;
      if (sg) ovf = (val > 64'sd2147483647) || (val < -64'sd2147483648);
      else    ovf = (val < 0) || (val > 64'sd4294967295);
      z   = ovf ? sat32(sg, s) : val[31:0];
      inx = (r != 0) && !ovf;
      return {1'b0, ovf, inx, z};
   endfunction

   function automatic int lat(input logic [31:0] a);
      int ex, e;
      ex = int'(a[30:23]);
      if (ex == 255 || ex - 127 >= 32 || (ex == 0 && a[22:0] == 0)) return 3;
      if (ex == 0) return 4;
      e = ex - 127;
      if (e >= 23) return 4 + (e - 23);
      return 4 + (((23 - e) > 25) ? 25 : (23 - e));
   endfunction

   // driver: holds in_stb until accepted; records expected result and output cycle
   task automatic send(input logic [31:0] a, input logic [1:0] rm, input logic sg);
      int n;
      @(posedge clk); #1;
      in_a      = a;
      in_rm     = rm;
      in_signed = sg;
      in_stb    = 1'b1;
      n = 0;
      while (!in_ack && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ack) begin
         chk("send_timeout", 64'(in_ack), 64'd1);
         in_stb = 1'b0;
      end else begin
         exp_q.push_back(model(a, rm, sg));
         lat_q.push_back(cyc + lat(a));
         @(posedge clk); #1;
         in_stb = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard compare process
   initial begin
      logic        stb_prev;
      logic [34:0] ex_v;
      int          t;
      stb_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stb_prev = 1'b0;
         end else begin
            if (out_stb && !stb_prev) begin
               if (lat_q.size() == 0) begin
                  chk("unexpected_out_stb", 64'(out_stb), 64'd0);
               end else begin
                  t = lat_q.pop_front();
                  chk("latency_cycle", 64'(cyc), 64'(t));
               end
            end
            if (out_stb && out_ack) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 64'(out_stb), 64'd0);
               end else begin
                  ex_v = exp_q.pop_front();
                  chk("out_z", 64'(out_z), 64'(ex_v[31:0]));
                  chk("out_flags", 64'(out_flags), 64'(ex_v[34:32]));
               end
            end
            stb_prev = out_stb;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int n;
      logic [34:0] mv;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_a      = '0;
      in_rm     = 2'd0;
      in_signed = 1'b0;
      in_stb    = 1'b0;
      out_ack   = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ack", 64'(in_ack), 64'd0);
      chk("rst_out_stb", 64'(out_stb), 64'd0);
      chk("rst_out_z", 64'(out_z), 64'd0);
      chk("rst_out_flags", 64'(out_flags), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ack_after_rst", 64'(in_ack), 64'd1);

      // pin the model to hand-computed values, then run the same vectors through the DUT
      chk("model_lat_one", 64'(lat(32'h3F800000)), 64'd27);
      chk("model_lat_nan", 64'(lat(32'h7FC00000)), 64'd3);
      for (int i = 0; i < 16; i++) begin
         mv = model(dv_a[i], dv_rm[i], dv_sg[i]);
         chk($sformatf("model_pin_%0d", i), 64'(mv), 64'({dv_f[i], dv_z[i]}));
         send(dv_a[i], dv_rm[i], dv_sg[i]);
      end

      for (int i = 0; i < 14; i++)
         for (int j = 0; j < 8; j++)
            send(sw_a[i], 2'(j % 4), (j >= 4));
      drain();

      // hold the result with out_ack low
      @(posedge clk); #1;
      out_ack = 1'b0;
      send(32'h3FC00000, 2'd0, 1'b1);
      n = 0;
      while (!out_stb && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hold_out_stb_seen", 64'(out_stb), 64'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_stb", 64'(out_stb), 64'd1);
         chk("hold_in_ack", 64'(in_ack), 64'd0);
         chk("hold_out_z", 64'(out_z), 64'd2);
      end
      @(posedge clk); #1;
      out_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_xfer_out_stb", 64'(out_stb), 64'd0);
      chk("post_xfer_in_ack", 64'(in_ack), 64'd0);
      @(negedge clk);
      chk("post_xfer_in_ack_rise", 64'(in_ack), 64'd1);

      // reset in the middle of ALIGN
      send(32'h3F800000, 2'd0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(posedge clk); #1;
      chk("midrst_out_stb", 64'(out_stb), 64'd0);
      chk("midrst_in_ack", 64'(in_ack), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_in_ack_rise", 64'(in_ack), 64'd1);

      // recovery after reset
      send(32'h40490FDB, 2'd0, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
